// File: rtl/seg7_scan_ctrl.sv
// 8-digit time-multiplexed seven-segment scan controller with tear-free frame-boundary updates.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] value,
  output logic        ready,
  output logic [7:0]  anode,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   shown;
  logic [31:0]   pending;

  logic          tick;
  logic          boundary;
  logic          apply;
  logic [2:0]    idx_next;
  logic [31:0]   shown_next;
  logic [3:0]    nib_next;
  logic [6:0]    seg_next;

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign tick     = (cnt == CNT_MAX);
  assign idx_next = (idx == 3'd0) ? 3'd7 : idx - 3'd1;
  assign boundary = tick && (idx_next == 3'd7);
  // ready low means a load is waiting; it is promoted only on a frame boundary
  assign apply      = boundary && !ready;
  assign shown_next = apply ? pending : shown;
  assign nib_next   = shown_next[{idx_next, 2'b00} +: 4];

`ifdef SEG7_LZ_BLANK_EN
  logic [7:0] zero_from;

  // zero_from[k]: nibbles k..7 of the value being shown are all zero
  always_comb begin
    zero_from = '0;
    for (int k = 0; k < 8; k++) begin
      zero_from[k] = ~|(shown_next >> (k * 4));
    end
  end

  assign seg_next = ((idx_next != 3'd0) && zero_from[idx_next]) ? 7'b1111111
                                                                 : hex_seg(nib_next);
`else
  assign seg_next = hex_seg(nib_next);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      idx        <= 3'd0;
      shown      <= '0;
      pending    <= '0;
      ready      <= 1'b1;
      anode      <= 8'hFF;
      seg        <= 7'b1111111;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;

      if (tick) begin
        cnt   <= '0;
        idx   <= idx_next;
        anode <= ~(8'h01 << idx_next);
        seg   <= seg_next;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (apply) begin
        shown <= pending;
        ready <= 1'b1;
      end else if (load && ready) begin
        pending <= value;
        ready   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl at REFRESH_DIV=4: reset, scan order, handshake, decode table, async reset.
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        load;
  logic [31:0] value;
  logic        ready;
  logic [7:0]  anode;
  logic [6:0]  seg;
  logic        frame_done;

  int passed = 0;
  int total  = 0;

`ifdef SEG7_LZ_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'b1111111;
`else
  localparam logic [6:0] LZ_SEG = 7'b0000001;
`endif

  seg7_scan_ctrl #(.REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .ready      (ready),
    .anode      (anode),
    .seg        (seg),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] value;
    int          digit;
    logic [6:0]  seg;
  } vec_t;

  vec_t vecs[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_frame(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_done && n < 40);
    check({name, "_frame_wait"}, {31'd0, frame_done}, 32'd1);
  endtask

  task automatic wait_anode(input string name, input logic [7:0] target);
    int n;
    n = 0;
    while (anode !== target && n < 40) begin
      step();
      n++;
    end
    check({name, "_anode_wait"}, {24'd0, anode}, {24'd0, target});
  endtask

  task automatic show_value(input logic [31:0] v);
    int n;
    n = 0;
    while (!ready && n < 40) begin
      step();
      n++;
    end
    load  = 1'b1;
    value = v;
    step();
    load = 1'b0;
    check("show_ready_low", {31'd0, ready}, 32'd0);
    wait_frame("show");
    check("show_ready_high", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{32'h5678_9EF0, 7, 7'b0100100};
    vecs[1]  = '{32'h5678_9EF0, 6, 7'b0100000};
    vecs[2]  = '{32'h5678_9EF0, 5, 7'b0001111};
    vecs[3]  = '{32'h5678_9EF0, 4, 7'b0000000};
    vecs[4]  = '{32'h5678_9EF0, 3, 7'b0000100};
    vecs[5]  = '{32'h5678_9EF0, 2, 7'b0110000};
    vecs[6]  = '{32'h5678_9EF0, 1, 7'b0111000};
    vecs[7]  = '{32'h5678_9EF0, 0, 7'b0000001};
    vecs[8]  = '{32'h0000_00A5, 7, LZ_SEG};
    vecs[9]  = '{32'h0000_00A5, 6, LZ_SEG};
    vecs[10] = '{32'h0000_00A5, 5, LZ_SEG};
    vecs[11] = '{32'h0000_00A5, 4, LZ_SEG};
    vecs[12] = '{32'h0000_00A5, 3, LZ_SEG};
    vecs[13] = '{32'h0000_00A5, 2, LZ_SEG};
    vecs[14] = '{32'h0000_00A5, 1, 7'b0001000};
    vecs[15] = '{32'h0000_00A5, 0, 7'b0100100};

    load  = 1'b0;
    value = '0;
    rst   = 1'b1;
    #2 rst = 1'b0;
    #10;
    check("rst_anode", {24'd0, anode}, 32'hFF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);

    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("blank_after_release", {24'd0, anode}, 32'hFF);
    end
    step();
    check("first_tick_anode", {24'd0, anode}, 32'h7F);
    check("first_tick_seg", {25'd0, seg}, {25'd0, LZ_SEG});
    check("first_tick_fd", {31'd0, frame_done}, 32'd1);

    // full scan: each digit held 4 clocks, frame_done only at the 32nd edge
    for (int s = 1; s <= 32; s++) begin
      int d;
      step();
      d = (7 - s / 4) & 7;
      check("scan_anode", {24'd0, anode}, {24'd0, ~(8'h01 << d)});
      check("scan_fd", {31'd0, frame_done}, {31'd0, (s == 32)});
    end

    // load, then a second load while busy that must be ignored
    step();
    load  = 1'b1;
    value = 32'h1234_ABCD;
    step();
    value = 32'hFFFF_FFFF;
    check("load_ready_low", {31'd0, ready}, 32'd0);
    step();
    load = 1'b0;
    check("busy_ready_low", {31'd0, ready}, 32'd0);
    wait_anode("old_value", 8'hFE);
    check("old_value_seg", {25'd0, seg}, 32'b0000001);
    wait_frame("load");
    check("load_anode", {24'd0, anode}, 32'h7F);
    check("load_seg_1", {25'd0, seg}, 32'b1001111);
    check("load_ready_high", {31'd0, ready}, 32'd1);
    repeat (28) step();
    check("load_d_anode", {24'd0, anode}, 32'hFE);
    check("load_d_seg", {25'd0, seg}, 32'b1000010);

    for (int i = 0; i < 16; i++) begin
      if (i == 0 || vecs[i].value != vecs[i-1].value) show_value(vecs[i].value);
      else repeat (4) step();
      check($sformatf("vec%0d_anode", i), {24'd0, anode}, {24'd0, ~(8'h01 << vecs[i].digit)});
      check($sformatf("vec%0d_seg", i), {25'd0, seg}, {25'd0, vecs[i].seg});
    end

    // async reset mid-frame with a pending load
    load  = 1'b1;
    value = 32'h1234_ABCD;
    step();
    load = 1'b0;
    wait_anode("mid_frame", 8'hF7);
    #2 rst = 1'b0;
    #1;
    check("async_anode", {24'd0, anode}, 32'hFF);
    check("async_seg", {25'd0, seg}, 32'h7F);
    check("async_ready", {31'd0, ready}, 32'd1);
    check("async_fd", {31'd0, frame_done}, 32'd0);
    @(negedge clk) rst = 1'b1;
    wait_frame("restart");
    check("restart_anode", {24'd0, anode}, 32'h7F);
    check("restart_seg7", {25'd0, seg}, {25'd0, LZ_SEG});
    repeat (28) step();
    check("restart_digit0_anode", {24'd0, anode}, 32'hFE);
    check("restart_digit0_seg", {25'd0, seg}, 32'b0000001);

    // load accepted on the boundary edge itself waits a whole frame
    repeat (3) step();
    load  = 1'b1;
    value = 32'h9000_0000;
    step();
    load = 1'b0;
    check("bnd_load_fd", {31'd0, frame_done}, 32'd1);
    check("bnd_load_ready", {31'd0, ready}, 32'd0);
    check("bnd_load_old_seg", {25'd0, seg}, {25'd0, LZ_SEG});
    repeat (32) step();
    check("bnd_apply_fd", {31'd0, frame_done}, 32'd1);
    check("bnd_apply_ready", {31'd0, ready}, 32'd1);
    check("bnd_apply_seg", {25'd0, seg}, 32'b0000100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
